// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential multiplier datapath.
package mult_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Step counter must hold values 0..w.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/ripple_add_w.sv
// Parameterized ripple-carry adder built from a chain of full-adder cells.
module ripple_add_w #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1]   = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[WIDTH];

endmodule

// File: rtl/seq_mult4.sv
// Unsigned shift-and-add multiplier: one add/shift step per clock, WIDTH steps per product.
module seq_mult4
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned     CntW    = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e          state_q;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] q_q;
  logic [CntW-1:0]  cnt_q;

  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic [WIDTH-1:0] step_a;
  logic             step_c;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] q_d;

  ripple_add_w #(
    .WIDTH (WIDTH)
  ) u_add (
    .a    (acc_q),
    .b    (m_q),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // The carry is consumed by the shift in the same step, so it never needs a register.
  always_comb begin
    step_c = 1'b0;
    step_a = acc_q;
    if (q_q[0]) begin
      step_c = add_cout;
      step_a = add_sum;
    end
    acc_d = {step_c, step_a[WIDTH-1:1]};
    q_d   = {step_a[0], q_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            m_q     <= a;
            q_q     <= b;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          acc_q <= acc_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            state_q <= StDone;
            busy    <= 1'b0;
            done    <= 1'b1;
            product <= {acc_d, q_d};
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult4.sv
// Directed and sweep checks for seq_mult4 at WIDTH=4 and WIDTH=8.
module tb_seq_mult4;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  a;
  logic [3:0]  b;
  logic        busy;
  logic        done;
  logic [7:0]  product;

  logic        start8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        busy8;
  logic        done8;
  logic [15:0] product8;

  int unsigned checks;
  int unsigned errors;
  logic [7:0]  last_prod;

  seq_mult4 #(
    .WIDTH (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  seq_mult4 #(
    .WIDTH (8)
  ) dut8 (
    .clk     (clk),
    .rst     (rst),
    .start   (start8),
    .a       (a8),
    .b       (b8),
    .busy    (busy8),
    .done    (done8),
    .product (product8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full multiply on the 4-bit unit with exact cycle-by-cycle expectations.
  task automatic run4(input string tag, input logic [3:0] x, input logic [3:0] y,
                      input logic [7:0] exp, input bit scramble);
    tick();
    a = x;
    b = y;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq({tag, " busy"}, {31'd0, busy}, 32'd1);
      check_eq({tag, " done_low"}, {31'd0, done}, 32'd0);
      check_eq({tag, " hold"}, {24'd0, product}, {24'd0, last_prod});
      if (scramble) begin
        a = a + 4'd5;
        b = b ^ 4'hA;
      end
      tick();
    end
    check_eq({tag, " done"}, {31'd0, done}, 32'd1);
    check_eq({tag, " busy_off"}, {31'd0, busy}, 32'd0);
    check_eq({tag, " product"}, {24'd0, product}, {24'd0, exp});
    last_prod = exp;
    tick();
    check_eq({tag, " done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    last_prod = 8'd0;
    rst       = 1'b1;
    start     = 1'b0;
    a         = 4'd0;
    b         = 4'd0;
    start8    = 1'b0;
    a8        = 8'd0;
    b8        = 8'd0;

    // Reset for two cycles, start held high to show reset wins.
    start = 1'b1;
    tick();
    check_eq("rst busy", {31'd0, busy}, 32'd0);
    check_eq("rst done", {31'd0, done}, 32'd0);
    check_eq("rst product", {24'd0, product}, 32'd0);
    tick();
    check_eq("rst busy2", {31'd0, busy}, 32'd0);
    start = 1'b0;
    rst   = 1'b0;

    run4("10x11", 4'd10, 4'd11, 8'h6E, 1'b0);
    run4("15x15", 4'd15, 4'd15, 8'hE1, 1'b0);
    run4("0x9", 4'd0, 4'd9, 8'h00, 1'b0);
    run4("9x0", 4'd9, 4'd0, 8'h00, 1'b0);
    run4("12x13_scr", 4'd12, 4'd13, 8'd156, 1'b1);

    // Start held high: accept at edge k, DONE after k+4, IDLE after k+5, re-accept at k+6.
    tick();
    a = 4'd3;
    b = 4'd5;
    start = 1'b1;
    tick();
    a = 4'd7;
    b = 4'd6;
    for (int i = 0; i <= 11; i++) begin
      check_eq("held done", {31'd0, done}, {31'd0, (i == 4 || i == 10)});
      check_eq("held busy", {31'd0, busy}, {31'd0, (i <= 3 || (i >= 6 && i <= 9))});
      check_eq("held excl", {31'd0, busy & done}, 32'd0);
      if (i == 4) check_eq("held prod1", {24'd0, product}, 32'd15);
      if (i == 10) check_eq("held prod2", {24'd0, product}, 32'd42);
      if (i == 6) start = 1'b0;
      tick();
    end
    last_prod = 8'd42;

    // Reset during the second RUN cycle.
    a = 4'd13;
    b = 4'd11;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check_eq("abort busy_pre", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("abort busy", {31'd0, busy}, 32'd0);
    check_eq("abort done", {31'd0, done}, 32'd0);
    check_eq("abort product", {24'd0, product}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      check_eq("abort no_done", {31'd0, done}, 32'd0);
      check_eq("abort idle", {31'd0, busy}, 32'd0);
      tick();
    end
    last_prod = 8'd0;
    run4("6x7", 4'd6, 4'd7, 8'd42, 1'b0);

    // 8-bit instance: done exactly 8 cycles after accept.
    a8 = 8'd255;
    b8 = 8'd255;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check_eq("w8 busy", {31'd0, busy8}, 32'd1);
      check_eq("w8 done_low", {31'd0, done8}, 32'd0);
      tick();
    end
    check_eq("w8 done", {31'd0, done8}, 32'd1);
    check_eq("w8 product", {16'd0, product8}, 32'h0000FE01);
    tick();
    check_eq("w8 done_pulse", {31'd0, done8}, 32'd0);

    // Exhaustive 4-bit sweep against the reference multiply.
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        run4("sweep", 4'(x), 4'(y), 8'(x * y), 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
